fpu_cmd_sequencer: RTL and testbench

Parametrised command front-end for the single-precision FPU datapath. It buffers operation requests in a FIFO and issues them one at a time. Single-cycle units (fclass through fma) and iterative units (div, sqrt) are issued through separate paths; each result is captured with its exception flags and returned over a valid/ready response port. It also keeps sticky fflags and raises an interrupt, replacing the unqueued, single-shot result muxing of the current top.

---
 rtl/fpu_seq_pkg.sv | 49 ++++
 rtl/fpu_cmd_fifo.sv | 51 +++++
 rtl/fpu_cmd_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_fpu_cmd_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// Shared types for the FPU command sequencer: opcodes, the queued command
// record, FSM states and opcode-class helpers.
package fpu_seq_pkg;

    localparam int NUM_EXC   = 5;
    localparam int FPU_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_FCLASS = 4'd0,
        OP_SGNJ   = 4'd1,
        OP_CMP    = 4'd2,
        OP_MINMAX = 4'd3,
        OP_I2F    = 4'd4,
        OP_F2I    = 4'd5,
        OP_ADDSUB = 4'd6,
        OP_MUL    = 4'd7,
        OP_FMA    = 4'd8,
        OP_DIV    = 4'd9,
        OP_SQRT   = 4'd10
    } fpu_op_e;

    // The raw opcode is kept as a plain vector: codes 11-15 must survive the
    // FIFO so they can be reported as illegal.
    typedef struct packed {
        logic [3:0]           op;
        logic [1:0]           mod;
        logic [2:0]           frm;
        logic [FPU_WIDTH-1:0] a;
        logic [FPU_WIDTH-1:0] b;
        logic [FPU_WIDTH-1:0] c;
    } fpu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMB = 2'd1,
        ITER = 2'd2,
        RESP = 2'd3
    } seq_state_e;

    // Unused opcodes, and sgnj/cmp with the reserved modifier 3.
    function automatic logic is_illegal(input logic [3:0] op, input logic [1:0] mod);
        return (op > OP_SQRT) || (((op == OP_SGNJ) || (op == OP_CMP)) && (mod == 2'd3));
    endfunction

    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_SQRT);
    endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate count.
module fpu_cmd_fifo
    import fpu_seq_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type cmd_t = fpu_cmd_t
) (
    input  logic clk,
    input  logic rst_l,
    input  logic push_i,
    input  cmd_t wdata_i,
    input  logic pop_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    cmd_t        mem_q [DEPTH];
    logic        wr_en;
    logic        rd_en;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Advance the read/write pointers.
    always_ff @(posedge clk or negedge rst_l) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Write the storage array.
    // NOTE: storage has no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// FPU command front-end: queues commands, issues them one at a time to the
// single-cycle or iterative units and returns each result over a valid/ready
// response port with sticky flags and an interrupt pulse.
// Optional build macro FPU_ITER_TIMEOUT_EN adds an ITER watchdog (TIMEOUT,
// iter_cancel) that returns an NV result when div/sqrt never completes.
module fpu_cmd_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
`ifdef FPU_ITER_TIMEOUT_EN
    parameter int TIMEOUT     = 64,
`endif
    parameter bit IRQ_ON_DONE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [1:0]         cmd_mod,
    input  logic [2:0]         cmd_frm,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [WIDTH-1:0]   cmd_c,
    output logic [3:0]         iss_op,
    output logic [1:0]         iss_mod,
    output logic [2:0]         iss_frm,
    output logic [WIDTH-1:0]   iss_a,
    output logic [WIDTH-1:0]   iss_b,
    output logic [WIDTH-1:0]   iss_c,
    input  logic [WIDTH-1:0]   comb_result,
    input  logic [NUM_EXC-1:0] comb_exc,
    output logic               iter_start,
`ifdef FPU_ITER_TIMEOUT_EN
    output logic               iter_cancel,
`endif
    input  logic               iter_done,
    input  logic [WIDTH-1:0]   iter_result,
    input  logic [NUM_EXC-1:0] iter_exc,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [NUM_EXC-1:0] rsp_exc,
    output logic               rsp_illegal,
    output logic [NUM_EXC-1:0] fflags,
    input  logic               fflags_clr,
    output logic               busy,
    output logic               irq
);

    typedef struct packed {
        logic [3:0]       op;
        logic [1:0]       mod;
        logic [2:0]       frm;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } cmd_w_t;

    cmd_w_t             push_cmd;
    cmd_w_t             head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               rsp_fire;

    seq_state_e         state_q;
    logic [3:0]         iss_op_q;
    logic [1:0]         iss_mod_q;
    logic [2:0]         iss_frm_q;
    logic [WIDTH-1:0]   iss_a_q, iss_b_q, iss_c_q;
    logic               iter_start_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [NUM_EXC-1:0] rsp_exc_q;
    logic               rsp_illegal_q;
    logic [NUM_EXC-1:0] fflags_q, fflags_d;
    logic               irq_q;

    assign push_cmd = '{op: cmd_op, mod: cmd_mod, frm: cmd_frm, a: cmd_a, b: cmd_b, c: cmd_c};
    assign fifo_pop = (state_q == IDLE) && !fifo_empty;
    assign rsp_fire = rsp_valid_q && rsp_ready;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .cmd_t (cmd_w_t)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .push_i  (cmd_valid),
        .wdata_i (push_cmd),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef FPU_ITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          iter_timeout;

    // iter_done in the final watchdog cycle takes precedence over the cancel.
    assign iter_timeout = (state_q == ITER) && (cnt_q == CW'(TIMEOUT - 1)) && !iter_done;
    assign iter_cancel  = iter_timeout;

    // Count ITER cycles; restarted on every issue to the iterative unit.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)                cnt_q <= '0;
        else if (state_q != ITER)  cnt_q <= '0;
        else if (!iter_done)       cnt_q <= cnt_q + CW'(1);
    end
`endif

    // Sticky exception flags; a clear wins over a same-cycle OR-in.
    always_comb begin
        // NOTE: default first so no path leaves fflags_d unassigned (no latch).
        fflags_d = fflags_q;
        if (fflags_clr)    fflags_d = '0;
        else if (rsp_fire) fflags_d = fflags_q | rsp_exc_q;
    end

    // Sequencer FSM with registered issue, response, flag and irq outputs.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= IDLE;
            iss_op_q      <= '0;
            iss_mod_q     <= '0;
            iss_frm_q     <= '0;
            iss_a_q       <= '0;
            iss_b_q       <= '0;
            iss_c_q       <= '0;
            iter_start_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_exc_q     <= '0;
            rsp_illegal_q <= 1'b0;
            fflags_q      <= '0;
            irq_q         <= 1'b0;
        end else begin
            iter_start_q <= 1'b0;
            irq_q        <= 1'b0;
            fflags_q     <= fflags_d;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        iss_op_q  <= head.op;
                        iss_mod_q <= head.mod;
                        iss_frm_q <= head.frm;
                        iss_a_q   <= head.a;
                        iss_b_q   <= head.b;
                        iss_c_q   <= head.c;
                        if (is_illegal(head.op, head.mod)) begin
                            rsp_data_q    <= '0;
                            rsp_exc_q     <= '0;
                            rsp_illegal_q <= 1'b1;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= RESP;
                        end else if (is_iter(head.op)) begin
                            iter_start_q <= 1'b1;
                            state_q      <= ITER;
                        end else begin
                            state_q <= COMB;
                        end
                    end
                end
                COMB: begin
                    rsp_data_q    <= comb_result;
                    rsp_exc_q     <= comb_exc;
                    rsp_illegal_q <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end
                ITER: begin
                    if (iter_done) begin
                        rsp_data_q    <= iter_result;
                        rsp_exc_q     <= iter_exc;
                        rsp_illegal_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end
`ifdef FPU_ITER_TIMEOUT_EN
                    else if (iter_timeout) begin
                        rsp_data_q    <= '0;
                        rsp_exc_q     <= 5'b10000;
                        rsp_illegal_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        irq_q       <= (rsp_exc_q != '0) || rsp_illegal_q || IRQ_ON_DONE;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = !fifo_full;
    assign busy        = !fifo_empty || (state_q != IDLE);
    assign iss_op      = iss_op_q;
    assign iss_mod     = iss_mod_q;
    assign iss_frm     = iss_frm_q;
    assign iss_a       = iss_a_q;
    assign iss_b       = iss_b_q;
    assign iss_c       = iss_c_q;
    assign iter_start  = iter_start_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_exc     = rsp_exc_q;
    assign rsp_illegal = rsp_illegal_q;
    assign fflags      = fflags_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Scoreboard bench for fpu_cmd_sequencer: a behavioural datapath (combinational
// unit plus a fixed-latency div/sqrt responder) feeds the DUT; expected
// responses are queued when a command is accepted and compared on delivery.
module tb_fpu_cmd_sequencer;
    import fpu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [1:0]  cmd_mod = '0;
    logic [2:0]  cmd_frm = '0;
    logic [31:0] cmd_a = '0, cmd_b = '0, cmd_c = '0;
    logic [3:0]  iss_op;
    logic [1:0]  iss_mod;
    logic [2:0]  iss_frm;
    logic [31:0] iss_a, iss_b, iss_c;
    logic [31:0] comb_result;
    logic [4:0]  comb_exc;
    logic        iter_start;
    logic        iter_done = 1'b0;
    logic [31:0] iter_result = '0;
    logic [4:0]  iter_exc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_exc;
    logic        rsp_illegal;
    logic [4:0]  fflags;
    logic        fflags_clr = 1'b0;
    logic        busy;
    logic        irq;
`ifdef FPU_ITER_TIMEOUT_EN
    logic        iter_cancel;
    int          n_cancel = 0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  exc;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_rsp = 0;
    int          n_irq = 0;
    int          n_start = 0;
    logic [4:0]  fflags_m = '0;
    bit          irq_due = 1'b0;
    bit          iter_en = 1'b1;
    int          iter_lat = 10;

    always #5 clk = ~clk;

    fpu_cmd_sequencer dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_mod     (cmd_mod),
        .cmd_frm     (cmd_frm),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_c       (cmd_c),
        .iss_op      (iss_op),
        .iss_mod     (iss_mod),
        .iss_frm     (iss_frm),
        .iss_a       (iss_a),
        .iss_b       (iss_b),
        .iss_c       (iss_c),
        .comb_result (comb_result),
        .comb_exc    (comb_exc),
        .iter_start  (iter_start),
`ifdef FPU_ITER_TIMEOUT_EN
        .iter_cancel (iter_cancel),
`endif
        .iter_done   (iter_done),
        .iter_result (iter_result),
        .iter_exc    (iter_exc),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_exc     (rsp_exc),
        .rsp_illegal (rsp_illegal),
        .fflags      (fflags),
        .fflags_clr  (fflags_clr),
        .busy        (busy),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural single-cycle unit: {exc, result}.
    function automatic logic [36:0] comb_model(input logic [3:0] op, input logic [1:0] mod,
                                               input logic [2:0] frm, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] c);
        if (op == 4'd6 && mod == 2'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000)
            return {5'b00000, 32'h4040_0000};
        return {a[4:0] ^ b[4:0] ^ {frm, mod}, (a ^ {b[15:0], b[31:16]}) + c + {28'd0, op}};
    endfunction

    // Behavioural div/sqrt unit: {exc, result}.
    function automatic logic [36:0] iter_model(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] c);
        if (op == 4'd9 && b == 32'd0) return {5'b01000, 32'h7F80_0000};
        return {a[9:5] | 5'b00001, (a - b) ^ c};
    endfunction

    function automatic exp_t expect_of(input logic [3:0] op, input logic [1:0] mod,
                                       input logic [2:0] frm, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] c,
                                       input bit cancel);
        exp_t r;
        r.ill = 1'b0;
        if (op >= 4'd11 || ((op == 4'd1 || op == 4'd2) && mod == 2'd3)) begin
            r.data = '0; r.exc = '0; r.ill = 1'b1;
        end else if (cancel) begin
            r.data = '0; r.exc = 5'b10000;
        end else if (op == 4'd9 || op == 4'd10) begin
            {r.exc, r.data} = iter_model(op, a, b, c);
        end else begin
            {r.exc, r.data} = comb_model(op, mod, frm, a, b, c);
        end
        return r;
    endfunction

    assign {comb_exc, comb_result} = comb_model(iss_op, iss_mod, iss_frm, iss_a, iss_b, iss_c);

    // div/sqrt responder: completes iter_lat cycles after the start pulse.
    initial forever begin
        logic [3:0]  op_s;
        logic [31:0] a_s, b_s, c_s;
        @(negedge clk);
        if (rst_l && iter_start) begin
            n_start++;
            if (iter_en) begin
                op_s = iss_op; a_s = iss_a; b_s = iss_b; c_s = iss_c;
                repeat (iter_lat) @(negedge clk);
                iter_done = 1'b1;
                {iter_exc, iter_result} = iter_model(op_s, a_s, b_s, c_s);
                @(negedge clk);
                iter_done = 1'b0;
            end
        end
    end

    // Response monitor: compares every presented payload with the queue head.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #1;
        if (irq) n_irq++;
`ifdef FPU_ITER_TIMEOUT_EN
        if (iter_cancel) n_cancel++;
`endif
        if (!rst_l) begin
            irq_due = 1'b0;
        end else begin
            if (irq_due) begin
                check("irq_pulse", irq, 1);
                irq_due = 1'b0;
            end
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sb_q[0];
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_exc", rsp_exc, e.exc);
                    check("rsp_illegal", rsp_illegal, e.ill);
                    if (rsp_ready) begin
                        void'(sb_q.pop_front());
                        fflags_m |= e.exc;
                        n_rsp++;
                        irq_due = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [1:0] mod, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input bit cancel);
        int w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_mod = mod; cmd_frm = a[2:0] ^ 3'd5;
        cmd_a = a; cmd_b = b; cmd_c = c;
        while (!cmd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        sb_q.push_back(expect_of(op, mod, a[2:0] ^ 3'd5, a, b, c, cancel));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while ((sb_q.size() != 0 || busy) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check(tag, sb_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int starts;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_iss_a", iss_a, 0);
        check("rst_fflags", fflags, 0);
        check("rst_irq_start", {irq, iter_start}, 0);
        rst_l = 1'b1;

        // 1: single add, three-cycle latency from the push cycle
        send(4'd6, 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'd0, 0);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (rsp_valid) break;
            @(posedge clk);
            lat++;
        end
        check("comb_latency", lat, 3);
        drain("t1_drain");
        check("t1_fflags", fflags, fflags_m);

        // 2: divide by zero through the iterative path, then clear flags
        starts = n_start;
        send(4'd9, 2'd0, 32'h3F80_0000, 32'd0, 32'd0, 0);
        drain("t2_drain");
        check("t2_one_start", n_start - starts, 1);
        check("t2_fflags", fflags, 5'b01000);
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;
        fflags_m = '0;
        check("t2_fflags_clr", fflags, 0);

        // 3: illegal commands never reach a unit
        starts = n_start;
        send(4'd2, 2'd3, 32'h1234_5678, 32'h0BAD_F00D, 32'h1, 0);
        send(4'd13, 2'd0, 32'hCAFE_0001, 32'h2, 32'h3, 0);
        drain("t3_drain");
        check("t3_no_start", n_start - starts, 0);

        // 4: back-pressure fills the FIFO; responses stay ordered and stable
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(4'(i % 9), 2'(i), 32'h1000_0000 * (i + 1), 32'h0000_1111 * (i + 3), 32'(i), 0);
        @(negedge clk);
        check("t4_full_ready", cmd_ready, 0);
        check("t4_busy", busy, 1);
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
        send(4'd7, 2'd1, 32'h4120_0000, 32'h4080_0000, 32'h5, 0);
        drain("t4_drain");
        check("fflags_accum", fflags, fflags_m);

        // 5: reset in ITER; the late completion must be ignored
        iter_lat = 10;
        send(4'd10, 2'd0, 32'h4080_0000, 32'h0, 32'h0, 0);
        repeat (4) @(negedge clk);
        rst_l = 1'b0;
        sb_q.delete();
        fflags_m = '0;
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        check("t5_fflags", fflags, 0);

`ifdef FPU_ITER_TIMEOUT_EN
        // 6: watchdog cancels in ITER cycle 64; a completion in that cycle wins
        iter_en = 1'b0;
        send(4'd10, 2'd0, 32'h4100_0000, 32'h0, 32'h0, 1);
        lat = 0;
        while (!iter_start && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        lat = 1;
        while (!iter_cancel && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("t6_cancel_cycle", lat, 64);
        drain("t6a_drain");
        iter_en = 1'b1;
        iter_lat = 63;
        starts = n_cancel;
        send(4'd10, 2'd0, 32'h4100_0000, 32'h3, 32'h7, 0);
        drain("t6b_drain");
        check("t6_no_cancel", n_cancel - starts, 0);
`endif

        check("irq_count", n_irq, n_rsp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
